eh2_dec_gpr_wb_arb: RTL and testbench
=====================================

Name: eh2_dec_gpr_wb_arb

Overview:
- Schedules late (out-of-pipe) GPR writebacks onto the single shared GPR write port 3; the in-order pipeline lends that port when it is idle.
- Late writeback sources are non-blocking load return, divider result and a spare source.
- Each requester has a one-entry holding register. Requesters are served round-robin whenever the pipeline does not own the port.
- Also supports per-thread cancel and reports per-thread pending-writeback status to decode, so decode can stall on RAW hazards.

Parameters:
- NREQ, 3, number of writeback requesters (2..4); index 0 = nb-load, 1 = divider, 2 = spare.

Ports:
- clk  input  1  core clock
- rst_l  input  1  asynchronous active-low reset
- req_valid  input  NREQ  writeback request valid per requester
- req_ready  output  NREQ  holding register free; a request is accepted when valid & ready
- req_tid  input  NREQ  thread id per request
- req_addr  input  NREQ*5  destination GPR per request, requester i at [5i+4:5i]
- req_data  input  NREQ*32  write data, requester i at [32i+31:32i]
- port_busy  input  1  pipeline owns GPR write port 3 this cycle
- cancel_valid  input  1  kill all pending/incoming writebacks of cancel_tid
- cancel_tid  input  1  thread being cancelled
- wen  output  1  write enable to GPR port 3
- wtid  output  1  write thread id
- waddr  output  5  write address
- wd  output  32  write data
- pend  output  2  pend[t] = 1 when any holding register holds a thread-t entry
- pend_addr_hit  output  2  pend_addr_hit[t] = 1 when some held thread-t entry targets chk_addr
- chk_addr  input  5  decode source register for hazard check

Behaviour:
- Reset state: all hold_v = 0, rr_ptr = 0.
  - Consequences: req_ready = all 1, wen = 0, wtid = 0, waddr = 0, wd = 0, pend = 0, pend_addr_hit = 0.
- Holding register per requester: {hold_v, tid, addr, data}. req_ready[i] = ~hold_v[i], purely from flops (no combinational path from valid).
- Accept on rising edge when req_valid[i] & req_ready[i]. Capture rules:
  - addr == 0: accepted and discarded (hold_v stays 0; x0 is never written).
  - cancel_valid & req_tid == cancel_tid: accepted and discarded.
- Grant is combinational in cycle N from registered state:
  - Eligible requesters: hold_v[i] & ~(cancel_valid & tid[i] == cancel_tid).
  - If port_busy = 0 and any requester is eligible: pick the first eligible index searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - Drive wen = 1 and wtid/waddr/wd from the granted holding register. Otherwise wen = 0 and wtid/waddr/wd = 0.
- End of a granted cycle: hold_v[g] <= 0 and rr_ptr <= (g+1) mod NREQ.
  - rr_ptr is unchanged in cycles with no grant, including port_busy cycles.
- Cancel: at the edge, clear every hold_v whose tid == cancel_tid; the other thread's entries are untouched. A cancelled entry is never driven on wen in the cancel cycle.
- Minimum latency: accept at edge k, wen during cycle k+1. A freed register shows req_ready = 1 in the cycle after its grant (no same-cycle refill).
- Ordering: at most one write per cycle, so the 4-port GPR never sees a same-address collision originating from this block.
- pend and pend_addr_hit are computed from hold_v/tid/addr (flops), ignoring same-cycle cancel.
  - chk_addr == 0 always gives pend_addr_hit = 0.
- Reset asserted mid-operation: all held entries are lost immediately (async), outputs return to reset values.

Test Plan:
- Single request: req0 valid, tid 1, addr 5, data 0xDEADBEEF, port_busy = 0 -> next cycle wen = 1, wtid = 1, waddr = 5, wd = 0xDEADBEEF; req_ready[0] = 0 for exactly one cycle; pend[1] = 1 for one cycle.
- Round-robin: fill requesters 0, 1, 2 in the same cycle, rr_ptr = 0 -> grants in order 0, 1, 2 on consecutive cycles. Refill 0 and 2 with rr_ptr = 0 after granting 2 -> 0 then 2. Reissuing with ptr = 1 -> order 2, 0.
- port_busy held high for 4 cycles with 2 entries pending -> wen = 0 throughout, rr_ptr unchanged, req_ready stays 0. After release, grants resume from the saved pointer, one per cycle.
- Cancel: hold {t0, x3} in req0 and {t1, x7} in req1, assert cancel_valid with cancel_tid = 0 in the cycle req0 would win -> wen shows t1/x7, req0 entry dropped, pend = 2'b00 afterwards. A new t0 request presented during cancel is discarded.
- x0 write: req1 valid with addr 0 -> accepted (ready stays 1), never produces wen, pend unaffected.
- Hazard: hold {t1, x12} with port_busy = 1, chk_addr = 12 -> pend_addr_hit = 2'b10. With chk_addr = 13 -> 2'b00. Assert rst_l low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/eh2_dec_gpr_wb_arb.sv
// Late GPR writeback arbiter: one holding register per late-writeback source
// (nb-load, divider, spare), served round-robin onto GPR write port 3 in the
// cycles the in-order pipeline leaves that port idle. Supports per-thread
// cancel and reports per-thread pending writebacks for decode RAW stalls.
module eh2_dec_gpr_wb_arb #(
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_tid,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*32-1:0]   req_data,
    input  logic                 port_busy,
    input  logic                 cancel_valid,
    input  logic                 cancel_tid,
    output logic                 wen,
    output logic                 wtid,
    output logic [4:0]           waddr,
    output logic [31:0]          wd,
    output logic [1:0]           pend,
    output logic [1:0]           pend_addr_hit,
    input  logic [4:0]           chk_addr
);

    // Holding registers: valid bits and pointer are control (reset), payload is not.
    logic [NREQ-1:0] hold_v_q, hold_v_d;
    logic [NREQ-1:0] hold_tid_q;
    logic [4:0]      hold_addr_q [NREQ];
    logic [31:0]     hold_data_q [NREQ];
    logic [1:0]      rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] load;
    logic            gnt_vld;
    logic [1:0]      gnt_idx;
    logic [2:0]      cand;

    // A free register is ready; readiness never depends on this cycle's valid.
    assign req_ready = ~hold_v_q;

    // Entries of a thread being cancelled this cycle may not win the port.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = hold_v_q[i] & ~(cancel_valid & (hold_tid_q[i] == cancel_tid));
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!gnt_vld && !port_busy && elig[cand[1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[1:0];
            end
        end
    end

    // Write port drive: zeros whenever nothing is granted.
    always_comb begin
        wen   = gnt_vld;
        wtid  = 1'b0;
        waddr = 5'd0;
        wd    = 32'd0;
        if (gnt_vld) begin
            wtid  = hold_tid_q[gnt_idx];
            waddr = hold_addr_q[gnt_idx];
            wd    = hold_data_q[gnt_idx];
        end
    end

    // Pending status from flops only; held addresses are never x0.
    always_comb begin
        pend          = 2'b00;
        pend_addr_hit = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (hold_v_q[i]) begin
                pend[hold_tid_q[i]] = 1'b1;
                if ((hold_addr_q[i] == chk_addr) && (chk_addr != 5'd0)) begin
                    pend_addr_hit[hold_tid_q[i]] = 1'b1;
                end
            end
        end
    end

    // Next-state: retire grant, apply cancel, capture accepted requests.
    always_comb begin
        hold_v_d = hold_v_q;
        load     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld && (gnt_idx == 2'(i))) begin
                hold_v_d[i] = 1'b0;
            end
            if (cancel_valid && (hold_tid_q[i] == cancel_tid)) begin
                hold_v_d[i] = 1'b0;
            end
            // x0 targets and requests of a cancelled thread are accepted but dropped.
            if (req_valid[i] && !hold_v_q[i] && (req_addr[5*i +: 5] != 5'd0) &&
                !(cancel_valid && (req_tid[i] == cancel_tid))) begin
                hold_v_d[i] = 1'b1;
                load[i]     = 1'b1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == 2'(NREQ-1)) ? 2'd0 : gnt_idx + 2'd1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            hold_v_q <= '0;
            rr_ptr_q <= 2'd0;
        end else begin
            hold_v_q <= hold_v_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Payload capture on accept; qualified by hold_v so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (load[i]) begin
                hold_tid_q[i]  <= req_tid[i];
                hold_addr_q[i] <= req_addr[5*i +: 5];
                hold_data_q[i] <= req_data[32*i +: 32];
            end
        end
    end

endmodule

// File: tb/tb_eh2_dec_gpr_wb_arb.sv
// Bench for eh2_dec_gpr_wb_arb: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_eh2_dec_gpr_wb_arb;

    localparam int NREQ = 3;

    logic        clk;
    logic        rst_l;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_tid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        port_busy;
    logic        cancel_valid;
    logic        cancel_tid;
    logic        wen;
    logic        wtid;
    logic [4:0]  waddr;
    logic [31:0] wd;
    logic [1:0]  pend;
    logic [1:0]  pend_addr_hit;
    logic [4:0]  chk_addr;

    eh2_dec_gpr_wb_arb #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_tid      (req_tid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .port_busy    (port_busy),
        .cancel_valid (cancel_valid),
        .cancel_tid   (cancel_tid),
        .wen          (wen),
        .wtid         (wtid),
        .waddr        (waddr),
        .wd           (wd),
        .pend         (pend),
        .pend_addr_hit(pend_addr_hit),
        .chk_addr     (chk_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    logic [45:0] act;
    assign act = {wen, wtid, waddr, wd, req_ready, pend, pend_addr_hit};

    typedef struct {
        logic [2:0]  vld;
        logic [2:0]  tid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d;
        logic        busy, cv, ct;
        logic [4:0]  chk;
        logic [45:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: contents of each requester's slot plus the rotation start.
    bit          mv [3];
    bit          mt [3];
    logic [4:0]  ma [3];
    logic [31:0] md [3];
    int          mptr;

    function automatic logic [45:0] ex(logic w, logic t, logic [4:0] a, logic [31:0] d,
                                       logic [2:0] r, logic [1:0] p, logic [1:0] h);
        return {w, t, a, d, r, p, h};
    endfunction

    task automatic cmp(input string nm, input logic [45:0] e);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got {wen,wtid,waddr,wd,rdy,pend,hit}=%0h/%0h/%0h/%h/%b/%b/%b expected %0h/%0h/%0h/%h/%b/%b/%b",
                     nm, act[45], act[44], act[43:39], act[38:7], act[6:4], act[3:2], act[1:0],
                     e[45], e[44], e[43:39], e[38:7], e[6:4], e[3:2], e[1:0]);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] t, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] d,
                         input logic b, input logic cv, input logic ct, input logic [4:0] c);
        req_valid    = v;
        req_tid      = t;
        req_addr     = {a2, a1, a0};
        req_data     = {d + 32'd2, d + 32'd1, d};
        port_busy    = b;
        cancel_valid = cv;
        cancel_tid   = ct;
        chk_addr     = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [2:0] v, input logic [2:0] t, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] d,
                       input logic b, input logic cv, input logic ct, input logic [4:0] c,
                       input logic [45:0] e);
        vec_t r;
        r.vld = v; r.tid = t; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.d = d;
        r.busy = b; r.cv = cv; r.ct = ct; r.chk = c; r.exp = e;
        tbl.push_back(r);
    endtask

    function automatic int model_grant();
        int g = -1;
        if (!port_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (mptr + k) % NREQ;
                if (g < 0 && mv[i] && !(cancel_valid && mt[i] == cancel_tid)) g = i;
            end
        end
        return g;
    endfunction

    function automatic logic [45:0] model_out();
        int g = model_grant();
        logic [2:0] r = 3'b000;
        logic [1:0] p = 2'b00;
        logic [1:0] h = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            r[i] = !mv[i];
            if (mv[i]) begin
                p[mt[i]] = 1'b1;
                if (ma[i] == chk_addr && chk_addr != 5'd0) h[mt[i]] = 1'b1;
            end
        end
        if (g >= 0) return ex(1'b1, mt[g], ma[g], md[g], r, p, h);
        return ex(1'b0, 1'b0, 5'd0, 32'd0, r, p, h);
    endfunction

    task automatic model_edge();
        int g = model_grant();
        bit old_v [3];
        old_v = mv;
        for (int i = 0; i < NREQ; i++) begin
            if (g == i) mv[i] = 1'b0;
            if (cancel_valid && mt[i] == cancel_tid) mv[i] = 1'b0;
            if (req_valid[i] && !old_v[i] && req_addr[5*i +: 5] != 5'd0 &&
                !(cancel_valid && req_tid[i] == cancel_tid)) begin
                mv[i] = 1'b1;
                mt[i] = req_tid[i];
                ma[i] = req_addr[5*i +: 5];
                md[i] = req_data[32*i +: 32];
            end
        end
        if (g >= 0) mptr = (g + 1) % NREQ;
    endtask

    initial begin
        logic [45:0] idle;
        idle  = ex(1'b0, 1'b0, 5'd0, 32'd0, 3'b111, 2'b00, 2'b00);
        rst_l = 1'b0;
        drive(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        #12;
        cmp("reset_state", idle);
        rst_l = 1'b1;
        tick();

        // Directed table: single request, round-robin orders, x0 discard.
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, idle);
        add(3'b001, 3'b001,  5, 0,  0, 32'hDEADBEEF, 0, 0, 0,  0, idle);
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  5, ex(1, 1,  5, 32'hDEADBEEF, 3'b110, 2'b10, 2'b10));
        add(3'b100, 3'b000,  0, 0,  9, 32'h100,      0, 0, 0,  0, idle);
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, ex(1, 0,  9, 32'h102,  3'b011, 2'b01, 2'b00));
        add(3'b111, 3'b010,  1, 2,  3, 32'h1000,     0, 0, 0,  0, idle);
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, ex(1, 0,  1, 32'h1000, 3'b000, 2'b11, 2'b00));
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, ex(1, 1,  2, 32'h1001, 3'b001, 2'b11, 2'b00));
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, ex(1, 0,  3, 32'h1002, 3'b011, 2'b01, 2'b00));
        add(3'b101, 3'b101,  4, 0,  6, 32'h2000,     0, 0, 0,  0, idle);
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  4, ex(1, 1,  4, 32'h2000, 3'b010, 2'b10, 2'b10));
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, ex(1, 1,  6, 32'h2002, 3'b011, 2'b10, 2'b00));
        add(3'b001, 3'b000,  7, 0,  0, 32'h3000,     0, 0, 0,  0, idle);
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, ex(1, 0,  7, 32'h3000, 3'b110, 2'b01, 2'b00));
        add(3'b101, 3'b001, 10, 0, 11, 32'h4000,     0, 0, 0,  0, idle);
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, ex(1, 0, 11, 32'h4002, 3'b010, 2'b11, 2'b00));
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, ex(1, 1, 10, 32'h4000, 3'b110, 2'b10, 2'b00));
        add(3'b010, 3'b000,  0, 0,  0, 32'h5000,     0, 0, 0,  0, idle);
        add(3'b000, 3'b000,  0, 0,  0, 32'h0,        0, 0, 0,  0, idle);

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].vld, tbl[n].tid, tbl[n].a0, tbl[n].a1, tbl[n].a2, tbl[n].d,
                  tbl[n].busy, tbl[n].cv, tbl[n].ct, tbl[n].chk);
            #1;
            cmp($sformatf("table_row%0d", n), tbl[n].exp);
            tick();
        end

        // port_busy stall with two entries, pointer left at 1 by the table.
        drive(3'b011, 3'b010, 3, 7, 0, 32'h6000, 0, 0, 0, 0);
        #1; cmp("busy_fill", idle); tick();
        for (int n = 0; n < 4; n++) begin
            drive(3'b000, 3'b000, 0, 0, 0, 32'h0, 1, 0, 0, 0);
            #1; cmp($sformatf("busy_hold%0d", n), ex(0, 0, 0, 32'h0, 3'b100, 2'b11, 2'b00)); tick();
        end
        drive(3'b000, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        #1; cmp("busy_release1", ex(1, 1, 7, 32'h6001, 3'b100, 2'b11, 2'b00)); tick();
        #1; cmp("busy_release0", ex(1, 0, 3, 32'h6000, 3'b110, 2'b01, 2'b00)); tick();
        #1; cmp("busy_drained", idle); tick();

        // Single grant on requester 1 moves the pointer to 2.
        drive(3'b010, 3'b000, 0, 1, 0, 32'h7000, 0, 0, 0, 0);
        #1; cmp("ptr_fill", idle); tick();
        drive(3'b000, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        #1; cmp("ptr_grant", ex(1, 0, 1, 32'h7001, 3'b101, 2'b01, 2'b00)); tick();

        // Cancel thread 0 in the cycle requester 0 would win; new t0 request dropped.
        drive(3'b011, 3'b010, 3, 7, 0, 32'h8000, 0, 0, 0, 0);
        #1; cmp("cancel_fill", idle); tick();
        drive(3'b100, 3'b000, 0, 0, 9, 32'h9000, 0, 1, 0, 0);
        #1; cmp("cancel_cycle", ex(1, 1, 7, 32'h8001, 3'b100, 2'b11, 2'b00)); tick();
        drive(3'b000, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        #1; cmp("cancel_after", idle); tick();

        // Hazard check under port_busy, then asynchronous reset mid-cycle.
        drive(3'b010, 3'b010, 0, 12, 0, 32'hA000, 1, 0, 0, 0);
        #1; cmp("hazard_fill", idle); tick();
        drive(3'b000, 3'b000, 0, 0, 0, 32'h0, 1, 0, 0, 12);
        #1; cmp("hazard_hit", ex(0, 0, 0, 32'h0, 3'b101, 2'b10, 2'b10)); tick();
        drive(3'b000, 3'b000, 0, 0, 0, 32'h0, 1, 0, 0, 13);
        #1; cmp("hazard_miss", ex(0, 0, 0, 32'h0, 3'b101, 2'b10, 2'b00));
        #1; rst_l = 1'b0;
        #1; cmp("async_reset", idle);
        tick();
        rst_l = 1'b1;
        drive(3'b000, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        #1; cmp("post_reset", idle); tick();

        // Randomized traffic against the model, starting from the reset state.
        for (int i = 0; i < NREQ; i++) begin
            mv[i] = 1'b0; mt[i] = 1'b0; ma[i] = 5'd0; md[i] = 32'd0;
        end
        mptr = 0;
        for (int n = 0; n < 400; n++) begin
            drive(3'($urandom), 3'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), 5'($urandom_range(0, 7)));
            #1;
            cmp($sformatf("random%0d", n), model_out());
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
